// File: rtl/datapath_arbiter.sv
// Two-requester round-robin arbiter feeding a single registered output stage.
// A grant is held for up to MAX_BURST captures or until the owner drops its request.
module datapath_arbiter #(
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        ack_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
);

  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_gnt;
  logic [1:0]        w_gnt_next;
  logic              r_rr_last;
  logic              w_rr_last_next;
  logic [3:0]        r_burst_cnt;
  logic [3:0]        w_burst_next;
  logic [3:0]        w_burst_inc;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;

  logic w_owner;
  logic w_owner_req;
  logic w_can_accept;
  logic w_capture;
  logic w_release;
  logic w_winner;

  assign w_owner      = r_gnt[1];
  assign w_owner_req  = |(req_i & r_gnt);
  assign w_can_accept = !r_out_valid || out_ready_i;
  assign w_burst_inc  = r_burst_cnt + 4'd1;
  // On contention the requester that did not own the last grant wins.
  assign w_winner     = (req_i == 2'b11) ? ~r_rr_last : req_i[1];
  assign w_release    = (r_state == S_GRANT) &&
                        (!w_owner_req || (w_capture && (w_burst_inc == LP_MAX_BURST)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= 2'b00;
      r_rr_last   <= 1'b1;
      r_burst_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_next;
      r_gnt       <= w_gnt_next;
      r_rr_last   <= w_rr_last_next;
      r_burst_cnt <= w_burst_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_gnt_next     = r_gnt;
    w_rr_last_next = r_rr_last;
    w_burst_next   = r_burst_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_i != 2'b00) begin
          w_state_next = S_GRANT;
          w_gnt_next   = w_winner ? 2'b10 : 2'b01;
          w_burst_next = 4'd0;
        end
      end
      S_GRANT: begin
        if (w_capture) begin
          w_burst_next = w_burst_inc;
        end
        if (w_release) begin
          w_state_next   = S_IDLE;
          w_gnt_next     = 2'b00;
          w_rr_last_next = w_owner;
          w_burst_next   = 4'd0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_gnt_next   = 2'b00;
        w_burst_next = 4'd0;
      end
    endcase
  end

  // Accept only from the current owner, and only when the output stage has room.
  always_comb begin
    ack_o = 2'b00;
    if (r_state == S_GRANT && w_can_accept) begin
      ack_o = r_gnt & req_i;
    end
    w_capture = |ack_o;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_owner ? data1_i : data0_i;
    end else if (r_out_valid && out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign gnt_o       = r_gnt;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter: single requester, contention, backpressure,
// early release and asynchronous reset, plus per-cycle protocol invariants.
module tb_datapath_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_i;
  logic [15:0] data0_i;
  logic [15:0] data1_i;
  logic [1:0]  gnt_o;
  logic [1:0]  ack_o;
  logic        out_valid_o;
  logic [15:0] out_data_o;
  logic        out_ready_i;

  int checks   = 0;
  int failures = 0;

  datapath_arbiter #(.DATA_W(16), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .data0_i     (data0_i),
    .data1_i     (data1_i),
    .gnt_o       (gnt_o),
    .ack_o       (ack_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, check the combinational accept, then clock it.
  task automatic cyc(input logic [1:0] rq, input logic [15:0] d0, input logic [15:0] d1,
                     input logic rdy, input logic [1:0] exp_ack);
    req_i       = rq;
    data0_i     = d0;
    data1_i     = d1;
    out_ready_i = rdy;
    #1;
    chk("ack", 32'(ack_o), 32'(exp_ack));
    tick();
  endtask

  // Per-cycle invariants; data may only change across an edge that had an accept.
  initial begin
    logic        prev_ok;
    logic        prev_ack;
    logic [15:0] prev_data;
    prev_ok   = 1'b0;
    prev_ack  = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ack_onehot", 32'($onehot0(ack_o)), 32'd1);
        chk("gnt_onehot", 32'($onehot0(gnt_o)), 32'd1);
        chk("ack_in_gnt", 32'(ack_o & ~gnt_o), 32'd0);
        if (prev_ok && !prev_ack) begin
          chk("data_stable", 32'(out_data_o), 32'(prev_data));
        end
      end
      prev_ok   = rst;
      prev_ack  = |ack_o;
      prev_data = out_data_o;
    end
  end

  initial begin
    rst         = 1'b0;
    req_i       = 2'b00;
    data0_i     = '0;
    data1_i     = '0;
    out_ready_i = 1'b0;
    tick();
    chk("rst_gnt",   32'(gnt_o), 32'd0);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_data",  32'(out_data_o), 32'd0);
    chk("rst_ack",   32'(ack_o), 32'd0);
    tick();
    rst = 1'b1;

    // Single requester: burst of 4, one idle cycle, regrant.
    cyc(2'b01, 16'd1, 16'd0, 1'b1, 2'b00);
    chk("a_gnt0", 32'(gnt_o), 32'd1);
    chk("a_val0", 32'(out_valid_o), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc(2'b01, 16'(i), 16'd0, 1'b1, 2'b01);
      chk("a_data", 32'(out_data_o), 32'(i));
      chk("a_val",  32'(out_valid_o), 32'd1);
      chk("a_gnt",  32'(gnt_o), (i == 4) ? 32'd0 : 32'd1);
    end
    cyc(2'b01, 16'd5, 16'd0, 1'b1, 2'b00);
    chk("a_regnt",   32'(gnt_o), 32'd1);
    chk("a_drain",   32'(out_valid_o), 32'd0);
    chk("a_hold",    32'(out_data_o), 32'd4);
    cyc(2'b01, 16'd5, 16'd0, 1'b1, 2'b01);
    chk("a_data5",   32'(out_data_o), 32'd5);
    cyc(2'b00, 16'd5, 16'd0, 1'b1, 2'b00);
    chk("a_rel_gnt", 32'(gnt_o), 32'd0);
    chk("a_rel_val", 32'(out_valid_o), 32'd0);

    // Asynchronous reset mid-grant with a held word.
    cyc(2'b01, 16'h0077, 16'd0, 1'b1, 2'b00);
    chk("r_gnt", 32'(gnt_o), 32'd1);
    cyc(2'b01, 16'h0077, 16'd0, 1'b1, 2'b01);
    chk("r_data", 32'(out_data_o), 32'h77);
    out_ready_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("r_async_gnt",  32'(gnt_o), 32'd0);
    chk("r_async_val",  32'(out_valid_o), 32'd0);
    chk("r_async_data", 32'(out_data_o), 32'd0);
    chk("r_async_ack",  32'(ack_o), 32'd0);
    tick();
    req_i       = 2'b11;
    data0_i     = 16'h0012;
    data1_i     = 16'h0034;
    out_ready_i = 1'b1;
    #1;
    chk("r_low_ack", 32'(ack_o), 32'd0);
    rst = 1'b1;
    #1;
    chk("r_post_gnt", 32'(gnt_o), 32'd0);
    tick();

    // Contention from reset: requester 0 first, then 1, then 0 again.
    chk("c_gnt0", 32'(gnt_o), 32'd1);
    chk("c_val0", 32'(out_valid_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, 16'h0012, 16'h0034, 1'b1, 2'b01);
      chk("c_data0", 32'(out_data_o), 32'h12);
      chk("c_gnt0b", 32'(gnt_o), (i == 3) ? 32'd0 : 32'd1);
    end
    cyc(2'b11, 16'h0012, 16'h0034, 1'b1, 2'b00);
    chk("c_gnt1", 32'(gnt_o), 32'd2);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, 16'h0012, 16'h0034, 1'b1, 2'b10);
      chk("c_data1", 32'(out_data_o), 32'h34);
      chk("c_gnt1b", 32'(gnt_o), (i == 3) ? 32'd0 : 32'd2);
    end
    cyc(2'b11, 16'h0012, 16'h0034, 1'b1, 2'b00);
    chk("c_gnt0c", 32'(gnt_o), 32'd1);

    // Backpressure: hold 0x00AA, no accept, then drain and capture together.
    cyc(2'b01, 16'h00AA, 16'h0034, 1'b1, 2'b01);
    chk("b_data", 32'(out_data_o), 32'hAA);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 16'h00BB, 16'h0034, 1'b0, 2'b00);
      chk("b_hold", 32'(out_data_o), 32'hAA);
      chk("b_val",  32'(out_valid_o), 32'd1);
      chk("b_gnt",  32'(gnt_o), 32'd1);
    end
    cyc(2'b01, 16'h00BB, 16'h0034, 1'b1, 2'b01);
    chk("b_next",     32'(out_data_o), 32'hBB);
    chk("b_next_val", 32'(out_valid_o), 32'd1);

    // Early release after 2 captures; rr_last now points at requester 0.
    cyc(2'b00, 16'h00BB, 16'h0034, 1'b1, 2'b00);
    chk("e_gnt", 32'(gnt_o), 32'd0);
    chk("e_val", 32'(out_valid_o), 32'd0);
    chk("e_data", 32'(out_data_o), 32'hBB);
    cyc(2'b11, 16'h00BB, 16'h0055, 1'b1, 2'b00);
    chk("e_rr", 32'(gnt_o), 32'd2);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, 16'h00BB, 16'h0055, 1'b1, 2'b10);
      chk("e_data1", 32'(out_data_o), 32'h55);
      chk("e_gnt1",  32'(gnt_o), (i == 3) ? 32'd0 : 32'd2);
    end
    cyc(2'b00, 16'h0000, 16'h0000, 1'b1, 2'b00);
    chk("e_end_val", 32'(out_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_arbiter.md
DATAPATH_ARBITER -- requirements
Module: datapath_arbiter

Interface
REQ-001 Parameter DATA_W, default 16: width of every data bus.
REQ-002 Parameter MAX_BURST, default 4, legal 1..15: maximum captures per grant before forced release.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  2  per-requester request; bit k belongs to requester k.
REQ-006 data0_i  input  DATA_W  requester 0 payload.
REQ-007 data1_i  input  DATA_W  requester 1 payload.
REQ-008 gnt_o  output  2  registered one-hot grant (current owner); 2'b00 when idle.
REQ-009 ack_o  output  2  combinational per-requester accept; payload of requester k is captured on the edge where ack_o[k]=1.
REQ-010 out_valid_o  output  1  registered output stage holds valid data.
REQ-011 out_data_o  output  DATA_W  registered output payload.
REQ-012 out_ready_i  input  1  downstream accepts out_data_o on the edge where out_valid_o=1 and out_ready_i=1.

Function
REQ-013 FSM has exactly two states: IDLE (no owner) and GRANT (one owner, reflected in gnt_o).
REQ-014 IDLE, req_i!=0: next edge enters GRANT with owner chosen by round-robin; no capture in that cycle.
REQ-015 Round-robin: rr_last register holds last owner; on contention the requester != rr_last wins; single request always wins.
REQ-016 rr_last updates to the owner when a grant is released.
REQ-017 can_accept = !out_valid_o | out_ready_i.
REQ-018 ack_o[k] = gnt_o[k] & req_i[k] & can_accept; at most one bit of ack_o high.
REQ-019 On an ack edge: out_data_o <= owner payload, out_valid_o <= 1, burst_cnt <= burst_cnt+1.
REQ-020 Drain without capture (out_valid_o & out_ready_i & no ack): out_valid_o <= 0, out_data_o holds.
REQ-021 Simultaneous capture and drain: out_valid_o stays 1, new data replaces old; sustained throughput 1 word/cycle.
REQ-022 out_valid_o=1, out_ready_i=0: out_data_o and out_valid_o held stable; ack_o=0; grant retained.
REQ-023 out_ready_i while out_valid_o=0: ignored.
REQ-024 GRANT release -> IDLE on next edge when: owner req_i bit low (no capture that cycle), or capture brings burst_cnt to MAX_BURST.
REQ-025 burst_cnt (4 bits) clears to 0 on entry to GRANT; never exceeds MAX_BURST.
REQ-026 Released owner still requesting, other not requesting: regranted after exactly one IDLE cycle.
REQ-027 Release with other requester pending: other requester owns the next grant.
REQ-028 Latency: req_i rise sampled at edge E -> gnt_o at E; first capture at E+1 if can_accept; out_valid_o high after E+1.
REQ-029 gnt_o=2'b00 in IDLE; ack_o=0 in IDLE.

Reset
REQ-030 rst low forces immediately, regardless of clk: state IDLE, gnt_o=0, out_valid_o=0, out_data_o=0, burst_cnt=0, rr_last=1 (requester 0 wins first contention).
REQ-031 ack_o=0 while rst low (follows from gnt_o=0).
REQ-032 Reset mid-transfer discards the held output word; no partial state survives; first edge after rst high behaves as IDLE.

Verification
REQ-033 Reset: rst low mid-GRANT with out_valid_o=1 -> outputs zero before next clk edge; after release, gnt_o=00.
REQ-034 Single requester: req_i=01, data0_i=1,2,3,4,5 per ack, out_ready_i=1, MAX_BURST=4 -> out_data_o 1,2,3,4, one IDLE cycle, regrant, then 5.
REQ-035 Contention: req_i=11 from reset, data0_i=12, data1_i=34, out_ready_i=1 -> requester 0 granted first, 4 words of 12, then requester 1 gets 4 words of 34, then requester 0 again.
REQ-036 Backpressure: out_ready_i=0 after first capture of 0x00AA -> out_data_o=0x00AA held, ack_o=0 each cycle; out_ready_i=1 -> drain and next capture on same edge.
REQ-037 Early release: owner drops req_i after 2 captures -> IDLE next edge, burst_cnt cleared, rr_last=owner.
REQ-038 Bench checks every cycle: ack_o and gnt_o never multi-hot; ack_o implies gnt_o; out_data_o changes only on ack edges.
